// File: rtl/divekick_referee_if.sv
// Referee-side bundle: per-frame player inputs and HUD/controller decision outputs.
// The master side is the controller/HUD; the slave side is the referee.
interface divekick_referee_if #(
  parameter int COORD_W = 10
);
  logic               frame_tick;
  logic [COORD_W-1:0] P1_X, P1_Y, P2_X, P2_Y;
  logic [COORD_W-1:0] P1_HB_Width, P1_HB_Height, P2_HB_Width, P2_HB_Height;
  logic [2:0]         P1_Status, P2_Status;
  logic [3:0]         gameTime;
  logic               P1_Hit_Detected, P2_Hit_Detected;
  logic [3:0]         P1_Score, P2_Score;
  logic [1:0]         round_winner;
  logic               freeze;
  logic               round_start;
  logic               match_over;

  modport master (
    output frame_tick, P1_X, P1_Y, P2_X, P2_Y,
           P1_HB_Width, P1_HB_Height, P2_HB_Width, P2_HB_Height,
           P1_Status, P2_Status, gameTime,
    input  P1_Hit_Detected, P2_Hit_Detected, P1_Score, P2_Score,
           round_winner, freeze, round_start, match_over
  );

  modport slave (
    input  frame_tick, P1_X, P1_Y, P2_X, P2_Y,
           P1_HB_Width, P1_HB_Height, P2_HB_Width, P2_HB_Height,
           P1_Status, P2_Status, gameTime,
    output P1_Hit_Detected, P2_Hit_Detected, P1_Score, P2_Score,
           round_winner, freeze, round_start, match_over
  );
endinterface

// File: rtl/divekick_referee.sv
// Divekick per-frame referee: kick hit detection, round/match FSM, scores.
// Optional macro DIVEKICK_TIMEOUT_JUDGE_EN: timeout awards the round to the player nearer CENTER_X.
module divekick_referee #(
  parameter int COORD_W       = 10,
  parameter int CENTER_X      = 320,
  parameter int ROUNDS_TO_WIN = 3,
  parameter int PAUSE_FRAMES  = 90
) (
  input  logic              CLK,
  input  logic              Reset,
  divekick_referee_if.slave bus
);
  localparam int CW = COORD_W + 2;
  typedef logic signed [CW-1:0] coord_t;
  typedef enum logic [1:0] {S_FIGHT, S_PAUSE, S_OVER} state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d;
  logic [1:0] winner_q, winner_d;
  logic       p1_hit_q, p1_hit_d, p2_hit_q, p2_hit_d;
  logic       round_start_q, round_start_d;
  logic       p1_hits, p2_hits, p1_won, p2_won;
  logic [1:0] timeout_win;

  // Zero-extend into the widened signed domain so (X - size) can go negative.
  function automatic coord_t ext(input logic [COORD_W-1:0] v);
    return $signed({2'b00, v});
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  function automatic logic kick_hits(
    input logic [COORD_W-1:0] ax, ay, aw, ah,
    input logic [2:0]         ast,
    input logic [COORD_W-1:0] dx, dy,
    input logic [2:0]         dst
  );
    coord_t ax_lo, ax_hi, t, b, l, r;
    logic   kicking;
    kicking = 1'b1;
    ax_lo   = ext(ax);
    ax_hi   = ext(ax);
    case (ast)
      3'd2:    ax_hi = ext(ax) + ext(aw);
      3'd3:    ax_lo = ext(ax) - ext(aw);
      default: kicking = 1'b0;
    endcase
    case (dst)
      3'd0:       begin t = coord_t'(21); b = coord_t'(44); l = coord_t'(30); r = coord_t'(30); end
      3'd1, 3'd4: begin t = coord_t'(38); b = coord_t'(44); l = coord_t'(28); r = coord_t'(28); end
      3'd2:       begin t = coord_t'(44); b = coord_t'(44); l = coord_t'(27); r = coord_t'(30); end
      3'd3:       begin t = coord_t'(44); b = coord_t'(44); l = coord_t'(30); r = coord_t'(27); end
      default:    begin t = coord_t'(44); b = coord_t'(44); l = coord_t'(30); r = coord_t'(30); end
    endcase
    return kicking
        && (ax_lo <= ext(dx) + r) && (ext(dx) - l <= ax_hi)
        && (ext(ay) <= ext(dy) + b) && (ext(dy) - t <= ext(ay) + ext(ah))
        && (ext(ay) <= ext(dy));
  endfunction

  assign p1_hits = kick_hits(bus.P1_X, bus.P1_Y, bus.P1_HB_Width, bus.P1_HB_Height, bus.P1_Status,
                             bus.P2_X, bus.P2_Y, bus.P2_Status);
  assign p2_hits = kick_hits(bus.P2_X, bus.P2_Y, bus.P2_HB_Width, bus.P2_HB_Height, bus.P2_Status,
                             bus.P1_X, bus.P1_Y, bus.P1_Status);
  assign p1_won  = p1_score_q >= 4'(ROUNDS_TO_WIN);
  assign p2_won  = p2_score_q >= 4'(ROUNDS_TO_WIN);

`ifdef DIVEKICK_TIMEOUT_JUDGE_EN
  coord_t d1, d2, dist1, dist2;
  always_comb begin
    d1    = ext(bus.P1_X) - coord_t'(CENTER_X);
    d2    = ext(bus.P2_X) - coord_t'(CENTER_X);
    dist1 = (d1 < 0) ? -d1 : d1;
    dist2 = (d2 < 0) ? -d2 : d2;
    if (dist1 < dist2)      timeout_win = 2'b01;
    else if (dist2 < dist1) timeout_win = 2'b10;
    else                    timeout_win = 2'b11;
  end
`else
  assign timeout_win = 2'b11;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    p1_score_d    = p1_score_q;
    p2_score_d    = p2_score_q;
    winner_d      = winner_q;
    p1_hit_d      = 1'b0;
    p2_hit_d      = 1'b0;
    round_start_d = 1'b0;
    case (state_q)
      S_FIGHT: if (bus.frame_tick) begin
        if (p1_hits || p2_hits) begin
          p1_hit_d = p1_hits;
          p2_hit_d = p2_hits;
          if (p1_hits) p1_score_d = sat_inc(p1_score_q);
          if (p2_hits) p2_score_d = sat_inc(p2_score_q);
          winner_d = {p2_hits, p1_hits};
          cnt_d    = 8'(PAUSE_FRAMES);
          state_d  = S_PAUSE;
        end else if (bus.gameTime == 4'd0) begin
          // A tie (11) from the judge leaves both scores untouched.
          if (timeout_win == 2'b01) p1_score_d = sat_inc(p1_score_q);
          if (timeout_win == 2'b10) p2_score_d = sat_inc(p2_score_q);
          winner_d = timeout_win;
          cnt_d    = 8'(PAUSE_FRAMES);
          state_d  = S_PAUSE;
        end
      end
      S_PAUSE: if (bus.frame_tick) begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          cnt_d = '0;
          if (p1_won || p2_won) begin
            winner_d = {p2_won, p1_won};
            state_d  = S_OVER;
          end else begin
            winner_d      = '0;
            round_start_d = 1'b1;
            state_d       = S_FIGHT;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q       <= S_FIGHT;
      cnt_q         <= '0;
      p1_score_q    <= '0;
      p2_score_q    <= '0;
      winner_q      <= '0;
      p1_hit_q      <= 1'b0;
      p2_hit_q      <= 1'b0;
      round_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      p1_score_q    <= p1_score_d;
      p2_score_q    <= p2_score_d;
      winner_q      <= winner_d;
      p1_hit_q      <= p1_hit_d;
      p2_hit_q      <= p2_hit_d;
      round_start_q <= round_start_d;
    end
  end

  assign bus.P1_Hit_Detected = p1_hit_q;
  assign bus.P2_Hit_Detected = p2_hit_q;
  assign bus.P1_Score        = p1_score_q;
  assign bus.P2_Score        = p2_score_q;
  assign bus.round_winner    = winner_q;
  assign bus.round_start     = round_start_q;
  assign bus.freeze          = (state_q != S_FIGHT);
  assign bus.match_over      = (state_q == S_OVER);
endmodule

// File: doc/divekick_referee.md
Name: divekick_referee

Overview:
Per-frame match referee for the two-player Divekick game.
- Samples both players' positions and status on each frame tick and detects kick hits against status-dependent hurtboxes.
- Runs a round/match state machine with a hit pause, score counters and match-over detection.
- Sits between the player controllers and the HUD/sprite logic. Drives freeze and round-restart to the controllers, and scores and winner to the HUD.

Parameters:
COORD_W, 10, coordinate and hitbox dimension width
CENTER_X, 320, screen centre column used by the timeout judge
ROUNDS_TO_WIN, 3, round wins needed to end the match (1..15)
PAUSE_FRAMES, 90, frames of freeze after a round is decided (1..255)

Ports:
CLK  in  1  system clock
Reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse, once per video frame
P1_X, P1_Y, P2_X, P2_Y  in  COORD_W  player anchor positions
P1_HB_Width, P1_HB_Height, P2_HB_Width, P2_HB_Height  in  COORD_W  kick hitbox size
P1_Status, P2_Status  in  3  0 idle, 1 jump, 2 kick right, 3 kick left, 4 fall
gameTime  in  4  round seconds remaining
P1_Hit_Detected, P2_Hit_Detected  out  1  one-cycle pulse: that player landed the deciding hit
P1_Score, P2_Score  out  4  rounds won
round_winner  out  2  00 none, 01 P1, 10 P2, 11 tie; held through PAUSE/OVER
freeze  out  1  players must ignore input
round_start  out  1  one-cycle pulse when a new round begins
match_over  out  1  high in OVER

Behaviour:
- Clocking and reset: one clock CLK. Reset is synchronous and active-high.
- Reset values: state FIGHT; all outputs 0; pause counter 0. Reset mid-pause or in OVER returns to FIGHT with scores cleared.
- Hurtbox sizes (top, bottom, left, right) by defender status:
  - idle: 21, 44, 30, 30
  - jump and fall: 38, 44, 28, 28
  - kick right: 44, 44, 27, 30
  - kick left: 44, 44, 30, 27
  - other codes: 44, 44, 30, 30
- Hit arithmetic: all compares use COORD_W+2 signed arithmetic. A negative (X - size) must never wrap to a large value.
- Kick right (status 2): attacker box is [X, X+HBW] x [Y, Y+HBH].
- Kick left (status 3): attacker box is [X-HBW, X] x [Y, Y+HBH].
- Defender box is [X-L, X+R] x [Y-T, Y+B].
- A hit requires inclusive overlap in both axes AND attacker Y <= defender Y. Non-kicking statuses never hit.
- FIGHT state, on frame_tick:
  - Hits: if either or both players hit, update score(s) and pulse the matching *_Hit_Detected.
  - round_winner: 01, 10, or 11 for a double hit (both players score).
  - Then load pause counter with PAUSE_FRAMES and go to PAUSE.
  - No hit and gameTime==0: timeout rule (see Optional Feature).
  - Hits take priority over timeout in the same frame.
- PAUSE state:
  - freeze=1.
  - Counter decrements on frame_tick.
  - On the tick that reaches 0: if either score >= ROUNDS_TO_WIN, go to OVER.
  - Otherwise go to FIGHT, pulse round_start for one cycle and clear round_winner.
- OVER state:
  - freeze=1 and match_over=1.
  - round_winner holds the match result: 11 if both scores reached ROUNDS_TO_WIN.
  - Held until Reset.
- Scores saturate at 15. Inputs are ignored when frame_tick=0.
- Latency: decision outputs are registered and valid the cycle after the frame_tick edge.

Optional Feature:
Macro: DIVEKICK_TIMEOUT_JUDGE_EN
- Defined: at timeout, compute |P1_X-CENTER_X| and |P2_X-CENTER_X| from each player's own X.
  - Closer player scores and round_winner is 01 or 10.
  - Equal distances give round_winner 11 with no score change.
  - Proceed to PAUSE.
- Undefined: timeout is always a draw. round_winner 11, no score change, proceed to PAUSE.

Test Plan:
- P1 (200,300) status 2 with HB 20x20; P2 (230,310) idle; frame_tick -> P1_Hit_Detected pulse, P1_Score=1, round_winner=01, freeze=1.
- Both kicking into each other at the same Y, mutually overlapping -> both pulses, both scores increment, round_winner=11.
- P1 at X=5 status 3, HBW=20; P2 at X=600 -> no hit; checks that X-HBW does not wrap.
- gameTime=0, P1_X=300, P2_X=400, no hits -> with macro: P1_Score+1, winner 01. Without macro: winner 11, scores unchanged.
- PAUSE_FRAMES=2: after decision, second frame_tick -> round_start pulse, freeze=0. Score reaching ROUNDS_TO_WIN instead gives match_over=1 held.
- Assert Reset during PAUSE -> next cycle FIGHT, scores 0, all outputs 0.
